// File: rtl/parking_time_tracker_pkg.sv
// Shared constants, slot-index width helper and output FSM states for the
// parking time tracker.
package parking_pkg;

    localparam int DEF_TW    = 8;
    localparam int DEF_SLOTS = 8;

    function automatic int slot_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } out_state_t;

endpackage

// File: rtl/parking_time_tracker_time_base.sv
// Time-of-day base: prescaler producing a one-cycle tick every TICK_DIV clocks
// and a modular TW-bit time counter advanced on each tick.
module time_base #(
    parameter int TW       = 8,
    parameter int TICK_DIV = 50
) (
    input  logic          clk,
    input  logic          rst,
    output logic          tick,
    output logic [TW-1:0] now
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            now   <= '0;
        end else if (tick) begin
            presc <= '0;
            now   <= now + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

endmodule

// File: rtl/parking_time_tracker.sv
// Per-slot entry timestamps plus a one-deep valid/ready output stage that
// presents (time_in, time_out) for an exiting car. Optional: OVERSTAY_FLAG_EN.
module parking_time_tracker
    import parking_pkg::*;
#(
    parameter int SLOTS    = DEF_SLOTS,
    parameter int TW       = DEF_TW,
    parameter int TICK_DIV = 50
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     entry_valid,
    input  logic [slot_w(SLOTS)-1:0] entry_slot,
    input  logic                     exit_valid,
    input  logic [slot_w(SLOTS)-1:0] exit_slot,
    output logic                     exit_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TW-1:0]            time_in,
    output logic [TW-1:0]            time_out,
    output logic [slot_w(SLOTS)-1:0] out_slot,
    output logic [TW-1:0]            now,
    output logic [SLOTS-1:0]         occupied,
    output logic                     err_entry,
    output logic                     err_exit,
    output logic                     out_overstay
);

    localparam int SW   = slot_w(SLOTS);
    localparam int NPAD = 2 ** SW;

    logic                     tick;
    logic [SLOTS-1:0][TW-1:0] stamp;
    logic [NPAD-1:0]          occ_pad;
    logic [NPAD-1:0]          in_range;
    out_state_t               state, state_nxt;
    logic                     exit_acc, exit_ok, entry_ok;

    time_base #(.TW(TW), .TICK_DIV(TICK_DIV)) u_time_base (
        .clk  (clk),
        .rst  (rst),
        .tick (tick),
        .now  (now)
    );

    // Out-of-range indices look empty and invalid so they fall into the error paths.
    for (genvar g = 0; g < NPAD; g++) begin : g_pad
        if (g < SLOTS) begin : g_in
            assign occ_pad[g]  = occupied[g];
            assign in_range[g] = 1'b1;
        end else begin : g_out
            assign occ_pad[g]  = 1'b0;
            assign in_range[g] = 1'b0;
        end
    end

    assign out_valid  = (state == HOLD);
    assign exit_ready = !out_valid || out_ready;

    // Exit is resolved first, so an entry to the slot being vacated is legal.
    always_comb begin
        exit_acc = exit_valid && exit_ready;
        exit_ok  = exit_acc && in_range[exit_slot] && occ_pad[exit_slot];
        entry_ok = entry_valid && in_range[entry_slot] &&
                   (!occ_pad[entry_slot] || (exit_ok && (entry_slot == exit_slot)));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (exit_ok) state_nxt = HOLD;
            HOLD:    if (out_ready && !exit_ok) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_in   <= '0;
            time_out  <= '0;
            out_slot  <= '0;
            err_entry <= 1'b0;
            err_exit  <= 1'b0;
        end else begin
            err_entry <= entry_valid && !entry_ok;
            err_exit  <= exit_acc && !exit_ok;
            if (exit_ok) begin
                time_in  <= stamp[exit_slot];
                time_out <= now;
                out_slot <= exit_slot;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupied <= '0;
            stamp    <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (exit_ok && (exit_slot == SW'(i)))
                    occupied[i] <= 1'b0;
                if (entry_ok && (entry_slot == SW'(i))) begin
                    occupied[i] <= 1'b1;
                    stamp[i]    <= now;
                end
            end
        end
    end

`ifdef OVERSTAY_FLAG_EN
    logic [SLOTS-1:0] ovr;

    // Flag when the stay reaches a full 2^TW ticks and the difference aliases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (entry_ok && (entry_slot == SW'(i)))
                    ovr[i] <= 1'b0;
                else if (tick && occupied[i] && ((now + TW'(1)) == stamp[i]))
                    ovr[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          out_overstay <= 1'b0;
        else if (exit_ok) out_overstay <= ovr[exit_slot];
    end
`else
    logic unused_tick;
    assign unused_tick  = tick;
    assign out_overstay = 1'b0;
`endif

endmodule

// File: tb/tb_parking_time_tracker.sv
// Directed bench for parking_time_tracker (TICK_DIV=4, TW=8, SLOTS=8).
module tb_parking_time_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       entry_valid, exit_valid, out_ready;
    logic [2:0] entry_slot, exit_slot, out_slot;
    logic       exit_ready, out_valid, err_entry, err_exit, out_overstay;
    logic [7:0] time_in, time_out, now;
    logic [7:0] occupied;

    int n_assert = 0;
    int n_fail   = 0;

    parking_time_tracker #(.SLOTS(8), .TW(8), .TICK_DIV(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .entry_valid  (entry_valid),
        .entry_slot   (entry_slot),
        .exit_valid   (exit_valid),
        .exit_slot    (exit_slot),
        .exit_ready   (exit_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .time_in      (time_in),
        .time_out     (time_out),
        .out_slot     (out_slot),
        .now          (now),
        .occupied     (occupied),
        .err_entry    (err_entry),
        .err_exit     (err_exit),
        .out_overstay (out_overstay)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        entry_valid = 1'b0;
        exit_valid  = 1'b0;
    endtask

    task automatic wait_now(input logic [7:0] v);
        int n = 0;
        while (now !== v && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_now", 32'(now), 32'(v));
    endtask

    task automatic enter(input logic [2:0] s);
        entry_valid = 1'b1; entry_slot = s;
        cyc();
        idle();
    endtask

    task automatic leave(input logic [2:0] s);
        exit_valid = 1'b1; exit_slot = s;
        cyc();
        idle();
    endtask

    initial begin
        rst = 1'b1; out_ready = 1'b1;
        entry_valid = 1'b0; exit_valid = 1'b0; entry_slot = '0; exit_slot = '0;
        repeat (2) @(negedge clk);
        chk("rst_now", 32'(now), 0);
        chk("rst_occ", 32'(occupied), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ready", 32'(exit_ready), 1);
        chk("rst_err", {30'd0, err_entry, err_exit}, 0);
        rst = 1'b0;

        // 1: basic entry/exit
        wait_now(8'd10); enter(3'd3);
        chk("s1_occ3", 32'(occupied[3]), 1);
        wait_now(8'd25); leave(3'd3);
        chk("s1_valid", 32'(out_valid), 1);
        chk("s1_tin", 32'(time_in), 10);
        chk("s1_tout", 32'(time_out), 25);
        chk("s1_slot", 32'(out_slot), 3);
        chk("s1_occ3_clr", 32'(occupied[3]), 0);
        cyc();
        chk("s1_drain", 32'(out_valid), 0);

        // 2: stay across the counter wrap
        wait_now(8'd250); enter(3'd0);
        wait_now(8'd4); leave(3'd0);
        chk("s2_tin", 32'(time_in), 250);
        chk("s2_tout", 32'(time_out), 4);
        chk("s2_dur", 32'(8'(time_out - time_in)), 10);
`ifdef OVERSTAY_FLAG_EN
        chk("s2_ovr", 32'(out_overstay), 0);
`endif
        cyc();

        // 3: double entry and empty exit
        wait_now(8'd6); enter(3'd2);
        wait_now(8'd8); enter(3'd5);
        enter(3'd5);
        chk("s3_err_entry", 32'(err_entry), 1);
        cyc();
        chk("s3_err_entry_pulse", 32'(err_entry), 0);
        leave(3'd6);
        chk("s3_err_exit", 32'(err_exit), 1);
        chk("s3_no_valid", 32'(out_valid), 0);
        cyc();
        chk("s3_err_exit_pulse", 32'(err_exit), 0);

        // 4: backpressure then back-to-back load
        out_ready = 1'b0;
        wait_now(8'd12); leave(3'd5);
        chk("s4_valid", 32'(out_valid), 1);
        chk("s4_tin_stamp_kept", 32'(time_in), 8);
        exit_valid = 1'b1; exit_slot = 3'd2;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("s4_hold_ready", 32'(exit_ready), 0);
            chk("s4_hold_pair", {8'd0, time_in, time_out, 5'd0, out_slot}, {8'd0, 8'd8, 8'd12, 8'd5});
            chk("s4_hold_valid", 32'(out_valid), 1);
        end
        wait_now(8'd20);
        chk("s4_occ2_kept", 32'(occupied[2]), 1);
        out_ready = 1'b1;
        cyc();
        idle();
        chk("s4_b2b_valid", 32'(out_valid), 1);
        chk("s4_b2b_pair", {8'd0, time_in, time_out, 5'd0, out_slot}, {8'd0, 8'd6, 8'd20, 8'd2});
        chk("s4_occ2_clr", 32'(occupied[2]), 0);
        cyc();

        // 5: same-cycle exit and re-entry on slot 1
        wait_now(8'd7); enter(3'd1);
        wait_now(8'd30);
        entry_valid = 1'b1; entry_slot = 3'd1;
        exit_valid  = 1'b1; exit_slot  = 3'd1;
        cyc();
        idle();
        chk("s5_pair", {16'd0, time_in, time_out}, {16'd0, 8'd7, 8'd30});
        chk("s5_occ1", 32'(occupied[1]), 1);
        chk("s5_errs", {30'd0, err_entry, err_exit}, 0);
        wait_now(8'd35); leave(3'd1);
        chk("s5_new_stamp", {16'd0, time_in, time_out}, {16'd0, 8'd30, 8'd35});
        cyc();

        // 6: asynchronous reset while holding
        wait_now(8'd40); enter(3'd4);
        wait_now(8'd41); enter(3'd7);
        out_ready = 1'b0;
        wait_now(8'd42); leave(3'd4);
        chk("s6_hold", 32'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("s6_valid", 32'(out_valid), 0);
        chk("s6_occ", 32'(occupied), 0);
        chk("s6_now", 32'(now), 0);
        chk("s6_ready", 32'(exit_ready), 1);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;

`ifdef OVERSTAY_FLAG_EN
        wait_now(8'd50); enter(3'd6);
        repeat (4 * 256 + 8) @(negedge clk);
        leave(3'd6);
        chk("ovr_valid", 32'(out_valid), 1);
        chk("ovr_tin", 32'(time_in), 50);
        chk("ovr_flag", 32'(out_overstay), 1);
        cyc();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_time_tracker.md
Name: parking_time_tracker

Overview:
Upstream feeder for the parking-duration subtractor.
- Maintains a free-running time-of-day counter and a per-slot entry timestamp.
- On a car exit, presents the registered pair time_out (current time) and time_in (stored entry time). The downstream 8-bit subtractor computes the parked duration from this pair.
- Provides a valid/ready output handshake so the pair is held stable until consumed.

Parameters:
SLOTS, 8, number of parking slots tracked
TW, 8, width of time values; must match the downstream subtractor width
TICK_DIV, 50, clk cycles per time unit (minimum 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
entry_valid  input  1  one-cycle request: car enters entry_slot
entry_slot  input  $clog2(SLOTS)  slot index for the entry
exit_valid  input  1  request: car leaves exit_slot; honoured only when exit_ready=1
exit_slot  input  $clog2(SLOTS)  slot index for the exit
exit_ready  output  1  exit request can be accepted this cycle
out_valid  output  1  time_in/time_out/out_slot are valid
out_ready  input  1  downstream consumes the pair
time_in  output  TW  stored entry timestamp of the exiting slot
time_out  output  TW  timestamp at exit acceptance
out_slot  output  $clog2(SLOTS)  slot of the presented pair
now  output  TW  current time counter
occupied  output  SLOTS  per-slot occupancy bits
err_entry  output  1  one-cycle pulse: entry to an occupied slot, ignored
err_exit  output  1  one-cycle pulse: exit from an empty slot, ignored
out_overstay  output  1  see Optional Feature

Behaviour:
Reset:
- All of the following are cleared to 0 asynchronously: now, prescaler, occupied, all timestamps, out_valid, time_in, time_out, out_slot, err_entry, err_exit, out_overstay.
- exit_ready=1 after reset.

Time base:
- Prescaler counts 0..TICK_DIV-1.
- tick is asserted in the cycle the prescaler equals TICK_DIV-1; the prescaler then returns to 0.
- now increments on tick and wraps from 2^TW-1 to 0 (modular). The downstream subtraction is modular, so durations below 2^TW are correct across the wrap.

Entry:
- Always accepted, with no backpressure.
- If the slot is free: set occupied[slot] and stamp[slot] <= now (the registered value before any same-cycle increment).
- If the slot is occupied: no state change; err_entry=1 in the next cycle.
- entry_slot >= SLOTS: treated as occupied, so err_entry is raised.

Output FSM: two states, EMPTY (out_valid=0) and HOLD (out_valid=1).
- exit_ready = !out_valid || out_ready (combinational).
- Exit accepted in cycle N (exit_valid && exit_ready) on an occupied slot:
  - in cycle N+1: time_in=stamp[slot], time_out=now sampled at N, out_slot=slot, out_valid=1;
  - occupied[slot] clears at N+1.
- Exit accepted on an empty or out-of-range slot: err_exit=1 at N+1; no output. The FSM goes to EMPTY if out_ready consumed the held pair, otherwise it is unchanged.
- HOLD with out_ready=1 and no new accepted exit: go to EMPTY.
- HOLD with out_ready=1 and a new accepted exit in the same cycle: load the new pair and stay in HOLD (back-to-back throughput of one per cycle).
- HOLD with out_ready=0: outputs are frozen; exit_ready=0.

Simultaneous entry and exit, same slot, same cycle (exit accepted):
- Exit is processed first and uses the old stamp.
- Entry then re-occupies the slot with stamp=now.
- Neither error is raised.

Simultaneous entry and exit, same slot, same cycle (exit not accepted):
- Entry is evaluated against the current occupancy.

Reset mid-operation: any held pair is discarded; all slots become free.

Optional Feature:
Macro OVERSTAY_FLAG_EN.
- Defined:
  - Each slot has an overstay bit, cleared on entry.
  - The bit is set on a tick where the slot is occupied and now+1 == stamp[slot], i.e. the duration has reached 2^TW.
  - out_overstay is loaded alongside the pair and is valid with out_valid; the downstream duration is then ambiguous.
- Not defined: no per-slot overstay bits exist; out_overstay is tied to 0.

Decomposition:
- Package parking_pkg holds:
  - the default TW and SLOTS constants;
  - the slot-index width function;
  - the output FSM state enum (EMPTY, HOLD).
- Sub-module time_base holds the prescaler and the now counter, with tick and now as outputs.
- The slot table and output FSM stay in parking_time_tracker.

Test Plan:
All scenarios use TICK_DIV=4 and TW=8.
1. Entry slot 3 at now=10, exit slot 3 at now=25 -> out_valid next cycle, time_in=10, time_out=25, out_slot=3, occupied[3]=0.
2. Entry slot 0 at now=250, exit at now=4 after the wrap -> time_in=250, time_out=4 (downstream duration 10); with OVERSTAY_FLAG_EN, out_overstay=0.
3. Entry slot 5 twice -> err_entry pulse after the second entry, stamp unchanged. Exit slot 6 while empty -> err_exit pulse, out_valid stays 0.
4. Hold out_ready=0 with a pair pending -> exit_ready=0 and outputs stable for 5 cycles. Raise out_ready with exit_valid on slot 2 -> the new pair loads in the next cycle, no bubble.
5. Same-cycle exit and entry on slot 1 (old stamp 7, now=30) -> pair (7,30); slot 1 stays occupied with stamp 30; no errors.
6. Assert rst while in HOLD with slots occupied -> out_valid, occupied and now are 0 immediately (asynchronous); exit_ready=1.
   With OVERSTAY_FLAG_EN: keep a slot occupied for 256 ticks -> out_overstay=1 on its exit.
